// File: rtl/planificador_pkg.sv
// Shared types and encodings for the elevator floor-request scheduler.
package planificador_pkg;

    typedef enum logic [2:0] {
        REPOSO   = 3'd0,
        SUBIENDO = 3'd1,
        BAJANDO  = 3'd2,
        PUERTAS  = 3'd3,
        FALLA    = 3'd4
    } estado_t;

    typedef enum logic {
        DIR_SUBE = 1'b0,
        DIR_BAJA = 1'b1
    } dir_t;

    localparam logic [1:0] MOTOR_PARO = 2'b00;
    localparam logic [1:0] MOTOR_SUBE = 2'b01;
    localparam logic [1:0] MOTOR_BAJA = 2'b10;

    function automatic logic [1:0] motor_de(input estado_t e);
        case (e)
            SUBIENDO: motor_de = MOTOR_SUBE;
            BAJANDO:  motor_de = MOTOR_BAJA;
            default:  motor_de = MOTOR_PARO;
        endcase
    endfunction

endpackage

// File: rtl/planificador_ascensor_buscador.sv
// Combinational search for pending requests above/below the car, plain and with one index masked.
module buscador_pendientes
    import planificador_pkg::*;
#(
    parameter int unsigned N_PISOS = 10,
    parameter int unsigned W       = 4
) (
    input  logic [N_PISOS-1:0] pendientes,
    input  logic [W-1:0]       piso,
    input  logic [W-1:0]       mascara,
    output logic               arriba_c,
    output logic               abajo_c,
    output logic               arriba_m_c,
    output logic               abajo_m_c
);

    always_comb begin
        arriba_c   = 1'b0;
        abajo_c    = 1'b0;
        arriba_m_c = 1'b0;
        abajo_m_c  = 1'b0;
        for (int i = 0; i < int'(N_PISOS); i++) begin
            if (pendientes[i]) begin
                if (W'(i) > piso) arriba_c = 1'b1;
                if (W'(i) < piso) abajo_c  = 1'b1;
                if (W'(i) != mascara) begin
                    if (W'(i) > piso) arriba_m_c = 1'b1;
                    if (W'(i) < piso) abajo_m_c  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/planificador_ascensor.sv
// SCAN elevator scheduler: latches requests, tracks position, drives motor and door requests.
// Optional watchdog fault state is built when PLAN_WATCHDOG_EN is defined.
module planificador_ascensor
    import planificador_pkg::*;
#(
    parameter int unsigned N_PISOS   = 10,
    parameter int unsigned WD_CICLOS = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_PISOS-1:0]         botones,
    input  logic [N_PISOS-1:0]         pisos,
    input  logic                       puertas_listo,
    output logic                       abrir,
    output logic [1:0]                 motor,
    output logic [N_PISOS-1:0]         pendientes,
    output logic [$clog2(N_PISOS)-1:0] piso_actual,
    output logic                       trabajando,
    output logic                       falla
);

    localparam int unsigned W = $clog2(N_PISOS);

    estado_t            estado, estado_sig;
    dir_t               dir, dir_sig;
    logic [W-1:0]       idx_c;
    logic               en_piso_c, llegada_c, borrar_c;
    logic               arriba_c, abajo_c, arriba_m_c, abajo_m_c;
    logic               wd_disparo_c;
    logic [N_PISOS-1:0] pend_sig_c;

    // Binary index of the active floor sensor
    always_comb begin
        idx_c = '0;
        for (int i = 0; i < int'(N_PISOS); i++) begin
            if (pisos[i]) idx_c = W'(i);
        end
    end

    assign en_piso_c  = $onehot(pisos);
    assign llegada_c  = en_piso_c && ((pisos & pendientes) != '0);
    assign borrar_c   = (estado == PUERTAS) && puertas_listo;
    assign pend_sig_c = (pendientes | botones) &
                        ~(borrar_c ? (N_PISOS'(1) << piso_actual) : '0);

    buscador_pendientes #(.N_PISOS(N_PISOS), .W(W)) u_buscador (
        .pendientes (pendientes),
        .piso       (piso_actual),
        .mascara    (piso_actual),
        .arriba_c   (arriba_c),
        .abajo_c    (abajo_c),
        .arriba_m_c (arriba_m_c),
        .abajo_m_c  (abajo_m_c)
    );

    always_comb begin
        estado_sig = estado;
        dir_sig    = dir;
        case (estado)
            REPOSO: begin
                if (en_piso_c && pisos[piso_actual] && pendientes[piso_actual]) begin
                    estado_sig = PUERTAS;
                end else if (arriba_c) begin
                    estado_sig = SUBIENDO;
                    dir_sig    = DIR_SUBE;
                end else if (abajo_c) begin
                    estado_sig = BAJANDO;
                    dir_sig    = DIR_BAJA;
                end
            end
            SUBIENDO: begin
                if (llegada_c)                            estado_sig = PUERTAS;
                else if (en_piso_c && pisos[N_PISOS-1])   estado_sig = REPOSO;
            end
            BAJANDO: begin
                if (llegada_c)                    estado_sig = PUERTAS;
                else if (en_piso_c && pisos[0])   estado_sig = REPOSO;
            end
            PUERTAS: begin
                // The served floor is masked out; keep direction first, then reverse
                if (puertas_listo) begin
                    if (dir == DIR_SUBE) begin
                        if (arriba_m_c) begin
                            estado_sig = SUBIENDO;
                        end else if (abajo_m_c) begin
                            estado_sig = BAJANDO;
                            dir_sig    = DIR_BAJA;
                        end else begin
                            estado_sig = REPOSO;
                        end
                    end else begin
                        if (abajo_m_c) begin
                            estado_sig = BAJANDO;
                        end else if (arriba_m_c) begin
                            estado_sig = SUBIENDO;
                            dir_sig    = DIR_SUBE;
                        end else begin
                            estado_sig = REPOSO;
                        end
                    end
                end
            end
`ifdef PLAN_WATCHDOG_EN
            FALLA:   estado_sig = FALLA;
`endif
            default: estado_sig = REPOSO;
        endcase
        if (wd_disparo_c) estado_sig = FALLA;
    end

    // State, request latch, position and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado      <= REPOSO;
            dir         <= DIR_SUBE;
            pendientes  <= '0;
            piso_actual <= '0;
            motor       <= MOTOR_PARO;
            abrir       <= 1'b0;
            trabajando  <= 1'b0;
        end else begin
            estado     <= estado_sig;
            dir        <= dir_sig;
            pendientes <= pend_sig_c;
            if (en_piso_c) piso_actual <= idx_c;
            motor      <= motor_de(estado_sig);
            abrir      <= (estado_sig == PUERTAS);
            trabajando <= (estado_sig != REPOSO);
        end
    end

`ifdef PLAN_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(WD_CICLOS + 1);

    logic [WDW-1:0]     wd_cnt;
    logic [N_PISOS-1:0] pisos_q;
    logic               en_marcha_c;

    assign en_marcha_c  = (estado == SUBIENDO) || (estado == BAJANDO);
    assign wd_disparo_c = en_marcha_c && (wd_cnt == WDW'(WD_CICLOS));

    // Motion watchdog: restarts on any sensor change or state change
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            pisos_q <= '0;
            falla   <= 1'b0;
        end else begin
            pisos_q <= pisos;
            falla   <= (estado_sig == FALLA);
            if ((estado_sig != estado) || (pisos != pisos_q)) begin
                wd_cnt <= '0;
            end else if (en_marcha_c && (wd_cnt != WDW'(WD_CICLOS))) begin
                wd_cnt <= wd_cnt + WDW'(1);
            end
        end
    end
`else
    assign wd_disparo_c = 1'b0;
    assign falla        = 1'b0;
`endif

endmodule

// File: tb/tb_planificador_ascensor.sv
// Directed vector bench for planificador_ascensor (10 floors).
module tb_planificador_ascensor;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] botones;
    logic [9:0] pisos;
    logic       puertas_listo;
    logic       abrir;
    logic [1:0] motor;
    logic [9:0] pendientes;
    logic [3:0] piso_actual;
    logic       trabajando;
    logic       falla;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] b;
        logic [9:0] p;
        logic       l;
        logic [1:0] m;
        logic       a;
        logic [9:0] pend;
        logic [3:0] piso;
        logic       t;
    } fila_t;

    fila_t vec[$];

    planificador_ascensor #(.N_PISOS(10), .WD_CICLOS(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .botones       (botones),
        .pisos         (pisos),
        .puertas_listo (puertas_listo),
        .abrir         (abrir),
        .motor         (motor),
        .pendientes    (pendientes),
        .piso_actual   (piso_actual),
        .trabajando    (trabajando),
        .falla         (falla)
    );

    always #5 clk = ~clk;

    function automatic void fila(input logic [9:0] b, input logic [9:0] p, input logic l,
                                 input logic [1:0] m, input logic a, input logic [9:0] pend,
                                 input logic [3:0] piso, input logic t);
        fila_t f;
        f.b = b; f.p = p; f.l = l; f.m = m; f.a = a; f.pend = pend; f.piso = piso; f.t = t;
        vec.push_back(f);
    endfunction

    // Compares {motor, abrir, pendientes, piso_actual, trabajando, falla}
    task automatic comprobar(input string nombre, input logic [1:0] m, input logic a,
                             input logic [9:0] pend, input logic [3:0] piso,
                             input logic t, input logic f);
        logic [18:0] act, exp;
        act = {motor, abrir, pendientes, piso_actual, trabajando, falla};
        exp = {m, a, pend, piso, t, f};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: motor=%b abrir=%b pend=%h piso=%0d trab=%b falla=%b, expected motor=%b abrir=%b pend=%h piso=%0d trab=%b falla=%b",
                     nombre, motor, abrir, pendientes, piso_actual, trabajando, falla,
                     m, a, pend, piso, t, f);
        end
    endtask

    initial begin
        //   botones  pisos   listo motor a  pend    piso t
        // Single trip 0 -> 5, then a stray door pulse while idle
        fila(10'h000, 10'h001, 0, 2'b00, 0, 10'h000, 0, 0);
        fila(10'h020, 10'h001, 0, 2'b00, 0, 10'h020, 0, 0);
        fila(10'h000, 10'h001, 0, 2'b01, 0, 10'h020, 0, 1);
        fila(10'h000, 10'h000, 0, 2'b01, 0, 10'h020, 0, 1);
        fila(10'h000, 10'h002, 0, 2'b01, 0, 10'h020, 1, 1);
        fila(10'h000, 10'h004, 0, 2'b01, 0, 10'h020, 2, 1);
        fila(10'h000, 10'h008, 0, 2'b01, 0, 10'h020, 3, 1);
        fila(10'h000, 10'h010, 0, 2'b01, 0, 10'h020, 4, 1);
        fila(10'h000, 10'h020, 0, 2'b00, 1, 10'h020, 5, 1);
        fila(10'h000, 10'h020, 0, 2'b00, 1, 10'h020, 5, 1);
        fila(10'h000, 10'h020, 1, 2'b00, 0, 10'h000, 5, 0);
        fila(10'h000, 10'h020, 1, 2'b00, 0, 10'h000, 5, 0);
        // Down to 3
        fila(10'h008, 10'h020, 0, 2'b00, 0, 10'h008, 5, 0);
        fila(10'h000, 10'h020, 0, 2'b10, 0, 10'h008, 5, 1);
        fila(10'h000, 10'h000, 0, 2'b10, 0, 10'h008, 5, 1);
        fila(10'h000, 10'h010, 0, 2'b10, 0, 10'h008, 4, 1);
        fila(10'h000, 10'h008, 0, 2'b00, 1, 10'h008, 3, 1);
        fila(10'h000, 10'h008, 1, 2'b00, 0, 10'h000, 3, 0);
        // SCAN: heading up to 7, floors 1 and 5 pressed on the way
        fila(10'h080, 10'h008, 0, 2'b00, 0, 10'h080, 3, 0);
        fila(10'h000, 10'h008, 0, 2'b01, 0, 10'h080, 3, 1);
        fila(10'h022, 10'h000, 0, 2'b01, 0, 10'h0A2, 3, 1);
        fila(10'h000, 10'h010, 0, 2'b01, 0, 10'h0A2, 4, 1);
        fila(10'h000, 10'h000, 0, 2'b01, 0, 10'h0A2, 4, 1);
        fila(10'h000, 10'h020, 0, 2'b00, 1, 10'h0A2, 5, 1);
        fila(10'h000, 10'h020, 1, 2'b01, 0, 10'h082, 5, 1);
        fila(10'h000, 10'h000, 0, 2'b01, 0, 10'h082, 5, 1);
        fila(10'h000, 10'h040, 0, 2'b01, 0, 10'h082, 6, 1);
        fila(10'h000, 10'h080, 0, 2'b00, 1, 10'h082, 7, 1);
        fila(10'h000, 10'h080, 1, 2'b10, 0, 10'h002, 7, 1);
        fila(10'h000, 10'h000, 0, 2'b10, 0, 10'h002, 7, 1);
        fila(10'h000, 10'h040, 0, 2'b10, 0, 10'h002, 6, 1);
        fila(10'h000, 10'h020, 0, 2'b10, 0, 10'h002, 5, 1);
        fila(10'h000, 10'h010, 0, 2'b10, 0, 10'h002, 4, 1);
        fila(10'h000, 10'h008, 0, 2'b10, 0, 10'h002, 3, 1);
        fila(10'h000, 10'h004, 0, 2'b10, 0, 10'h002, 2, 1);
        fila(10'h000, 10'h002, 0, 2'b00, 1, 10'h002, 1, 1);
        fila(10'h000, 10'h002, 1, 2'b00, 0, 10'h000, 1, 0);
        // Up to 4, then current-floor request and simultaneous press/clear
        fila(10'h010, 10'h002, 0, 2'b00, 0, 10'h010, 1, 0);
        fila(10'h000, 10'h002, 0, 2'b01, 0, 10'h010, 1, 1);
        fila(10'h000, 10'h004, 0, 2'b01, 0, 10'h010, 2, 1);
        fila(10'h000, 10'h008, 0, 2'b01, 0, 10'h010, 3, 1);
        fila(10'h000, 10'h010, 0, 2'b00, 1, 10'h010, 4, 1);
        fila(10'h000, 10'h010, 1, 2'b00, 0, 10'h000, 4, 0);
        fila(10'h010, 10'h010, 0, 2'b00, 0, 10'h010, 4, 0);
        fila(10'h000, 10'h010, 0, 2'b00, 1, 10'h010, 4, 1);
        fila(10'h000, 10'h010, 0, 2'b00, 1, 10'h010, 4, 1);
        fila(10'h010, 10'h010, 1, 2'b00, 0, 10'h000, 4, 0);
        fila(10'h000, 10'h010, 0, 2'b00, 0, 10'h000, 4, 0);
        // Multi-bit sensor pattern is ignored
        fila(10'h000, 10'h030, 0, 2'b00, 0, 10'h000, 4, 0);
        // Request behind the car is served on the return sweep
        fila(10'h100, 10'h010, 0, 2'b00, 0, 10'h100, 4, 0);
        fila(10'h000, 10'h010, 0, 2'b01, 0, 10'h100, 4, 1);
        fila(10'h000, 10'h020, 0, 2'b01, 0, 10'h100, 5, 1);
        fila(10'h010, 10'h000, 0, 2'b01, 0, 10'h110, 5, 1);
        fila(10'h000, 10'h040, 0, 2'b01, 0, 10'h110, 6, 1);
        fila(10'h000, 10'h080, 0, 2'b01, 0, 10'h110, 7, 1);
        fila(10'h000, 10'h100, 0, 2'b00, 1, 10'h110, 8, 1);
        fila(10'h000, 10'h100, 1, 2'b10, 0, 10'h010, 8, 1);
        fila(10'h000, 10'h080, 0, 2'b10, 0, 10'h010, 7, 1);
        fila(10'h000, 10'h040, 0, 2'b10, 0, 10'h010, 6, 1);
        fila(10'h000, 10'h020, 0, 2'b10, 0, 10'h010, 5, 1);
        fila(10'h000, 10'h010, 0, 2'b00, 1, 10'h010, 4, 1);
        fila(10'h000, 10'h010, 1, 2'b00, 0, 10'h000, 4, 0);

        rst = 1'b1;
        botones = '0;
        pisos = 10'h001;
        puertas_listo = 1'b0;
        #3;
        comprobar("reset", 2'b00, 0, 10'h000, 4'd0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vec.size(); i++) begin
            botones       = vec[i].b;
            pisos         = vec[i].p;
            puertas_listo = vec[i].l;
            @(posedge clk);
            #1;
            comprobar($sformatf("fila %0d", i), vec[i].m, vec[i].a, vec[i].pend,
                      vec[i].piso, vec[i].t, 1'b0);
            @(negedge clk);
        end

        // Asynchronous reset while moving up
        botones = 10'h200; puertas_listo = 1'b0; pisos = 10'h010;
        @(posedge clk); @(negedge clk);
        botones = 10'h000;
        @(posedge clk); #1;
        comprobar("arranque a 9", 2'b01, 0, 10'h200, 4'd4, 1, 0);
        @(negedge clk);
        pisos = 10'h000;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        comprobar("reset asincrono", 2'b00, 0, 10'h000, 4'd0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        pisos = 10'h010;
        @(posedge clk); #1;
        comprobar("tras reset", 2'b00, 0, 10'h000, 4'd4, 0, 0);
        @(posedge clk); #1;
        comprobar("reposo estable", 2'b00, 0, 10'h000, 4'd4, 0, 0);

`ifdef PLAN_WATCHDOG_EN
        begin
            bit visto;
            visto = 1'b0;
            @(negedge clk);
            botones = 10'h200;
            @(negedge clk);
            botones = 10'h000;
            pisos = 10'h000;
            for (int c = 0; c < 40 && !visto; c++) begin
                @(posedge clk); #1;
                if (falla) visto = 1'b1;
            end
            checks++;
            if (!visto) begin
                errors++;
                $display("FAIL watchdog: falla=%b after 40 cycles, expected 1", falla);
            end
            repeat (3) @(posedge clk);
            #1;
            comprobar("falla retenida", 2'b00, 0, 10'h200, 4'd4, 1, 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/planificador_ascensor.md
# planificador_ascensor

Floor-request scheduler for the elevator. Latches floor requests from the button inputs, tracks the car position from the one-hot floor sensors, and drives the motor using SCAN ordering: keep the current direction while requests remain ahead. At each served floor it hands a door cycle to the door controller and waits for completion. It sits between the button/sensor inputs and the door controller and motor driver.

## Interface
- `N_PISOS`, default 10, number of floors (≥2).
- `WD_CICLOS`, default 1024, watchdog limit in cycles (used only with the watchdog feature).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `botones` in N_PISOS: request level per floor (cab and hall ORed upstream).
- `pisos` in N_PISOS: floor sensors, one-hot at a floor, all-zero between floors.
- `puertas_listo` in 1: single-cycle pulse from the door controller; door cycle finished and doors locked.
- `abrir` out 1: door-cycle request, held high until `puertas_listo`.
- `motor` out 2: 00 stop, 01 up, 10 down (11 never driven).
- `pendientes` out N_PISOS: latched request register.
- `piso_actual` out $clog2(N_PISOS): binary index of the last floor sensed.
- `trabajando` out 1: high whenever the state is not REPOSO.
- `falla` out 1: watchdog fault flag.

## Operation
- **Reset values:** all outputs 0; state REPOSO; direction register `dir` = up.
- **Request latch:**
  - `pendientes[i]` sets on any cycle with `botones[i]=1`.
  - It clears only when the door cycle at floor i completes.
  - Clear has priority over set in the same cycle.
- **Position tracking:**
  - `piso_actual` loads when `pisos` is exactly one-hot.
  - It holds when `pisos` is all-zero or has more than one bit set; multi-bit patterns are ignored.
- **"At floor f"** means `pisos` is one-hot with bit f set.
- **Above / below:** `arriba` = any pending index > `piso_actual`; `abajo` = any pending index < `piso_actual`.
- **States:**
  - **REPOSO**, motor 00:
    - pending at the current floor and at floor → PUERTAS;
    - else `arriba` → SUBIENDO, `dir` = up;
    - else `abajo` → BAJANDO, `dir` = down.
  - **SUBIENDO**, motor 01:
    - at floor f with `pendientes[f]` → PUERTAS;
    - at floor N_PISOS-1 → REPOSO (guard case).
  - **BAJANDO**, motor 10:
    - at floor f with `pendientes[f]` → PUERTAS;
    - at floor 0 → REPOSO (guard case).
  - **PUERTAS**, motor 00, `abrir` 1. On `puertas_listo`, clear `pendientes[piso_actual]`, then choose the next state using `pendientes` with that bit masked:
    - requests ahead in `dir` → continue in `dir`;
    - else requests in the opposite direction → reverse;
    - else → REPOSO.
  - **FALLA**, watchdog build only: motor 00, `abrir` 0, `falla` 1. Exit only through `rst`. Requests keep latching.
- **Mid-floor requests:** a request for a floor the car is already passing between sensors is not stopped for. It is served on the return sweep.
- **`puertas_listo` outside PUERTAS** is ignored.
- **`rst` mid-motion:** immediate return to reset values, including `pendientes`.

## Timing
- All outputs are registered, and all decisions use inputs sampled at the same rising edge.
- **Request latch latency:** `botones[i]` at edge k → `pendientes[i]` visible after edge k.
- **Start latency:** a request latched after edge k is evaluated in REPOSO at edge k+1; `motor` is nonzero after edge k+1.
- **Arrival:** `pisos` at floor f with f pending at edge k → after edge k, `motor` = 00 and `abrir` = 1.
- **Door completion:** `puertas_listo` at edge k → after edge k:
  - `abrir` = 0;
  - the served bit is cleared;
  - `motor` already shows the next direction, or 00.
- **Back-to-back service:** no idle cycle between door completion and the next movement.

## Configuration
- **`PLAN_WATCHDOG_EN` defined:**
  - a counter resets on every change of `pisos` and on every state change;
  - it counts while in SUBIENDO or BAJANDO;
  - reaching WD_CICLOS forces FALLA on the next edge.
- **Undefined:** no counter, no FALLA state, and `falla` is tied 0.

## Structure
- Package `planificador_pkg` holds:
  - the state enum: REPOSO, SUBIENDO, BAJANDO, PUERTAS, FALLA;
  - motor encoding constants `MOTOR_PARO`, `MOTOR_SUBE`, `MOTOR_BAJA`;
  - the direction typedef.
- Sub-module `buscador_pendientes` (combinational) computes `arriba`, `abajo` and the masked variants from (`pendientes`, `piso_actual`, mask index). It is instantiated once.

## Test plan
1. **Reset:** assert `rst` mid-SUBIENDO → all outputs 0 asynchronously; after release, state is REPOSO.
2. **Single trip:** car at floor 0, pulse `botones[5]` → `motor`=01 two edges later; step `pisos` 1..5 → at 5, `motor`=00 and `abrir`=1; `puertas_listo` → `pendientes`=0, `trabajando`=0.
3. **SCAN order:** car at 3 heading up to 7; press floors 1 and 5 → stops at 5, then 7, then reverses (`motor`=10) and stops at 1.
4. **Current-floor request:** idle at floor 4, press `botones[4]` → `abrir`=1 and `motor` stays 00 throughout.
5. **Simultaneous press and clear:** `botones[4]` and `puertas_listo` together at floor 4 → `pendientes[4]`=0 afterwards.
6. **Watchdog (`PLAN_WATCHDOG_EN`, WD_CICLOS=16):** moving with `pisos`=0 for 16 cycles → `falla`=1, `motor`=00; state holds until `rst`.
